// File: rtl/mux4_arb_pkg.sv
// Shared types and sizes for the four-requester mux arbiter.
// Round-robin picking is enabled by MUX4_ARB_ROUND_ROBIN_EN.
package mux4_arb_pkg;
   localparam int N_REQ  = 4;
   localparam int ID_W   = 2;
   localparam int DATA_W = 4;

   typedef logic [ID_W-1:0] req_id_t;
   typedef enum logic {ST_EMPTY, ST_FULL} out_st_t;
endpackage

// File: rtl/mux_4_1.sv
// Team 4-bit 4:1 multiplexer.
module mux_4_1 (
   input  logic [3:0] in0,
   input  logic [3:0] in1,
   input  logic [3:0] in2,
   input  logic [3:0] in3,
   input  logic [1:0] sel,
   output logic [3:0] y
);
   always_comb begin
      unique case (sel)
         2'd0:    y = in0;
         2'd1:    y = in1;
         2'd2:    y = in2;
         default: y = in3;
      endcase
   end
endmodule

// File: rtl/rr_pick4.sv
// Combinational requester picker; rotating priority when
// MUX4_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [N_REQ-1:0] in_valid,
`ifdef MUX4_ARB_ROUND_ROBIN_EN
   input  req_id_t          ptr,
`endif
   output req_id_t          gnt,
   output logic             any
);
   always_comb begin
      gnt = '0;
      any = |in_valid;
      // Scan from lowest priority up so the last hit is the winner.
      for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef MUX4_ARB_ROUND_ROBIN_EN
         if (in_valid[ptr + req_id_t'(k)])
            gnt = ptr + req_id_t'(k);
`else
         if (in_valid[k[ID_W-1:0]])
            gnt = req_id_t'(k);
`endif
      end
   end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four-requester arbiter feeding a shared 4:1 mux into a one-entry
// output register. Round-robin via MUX4_ARB_ROUND_ROBIN_EN.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int RESET_PTR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  in_valid,
   input  logic [DATA_W-1:0] in_data0,
   input  logic [DATA_W-1:0] in_data1,
   input  logic [DATA_W-1:0] in_data2,
   input  logic [DATA_W-1:0] in_data3,
   output logic [N_REQ-1:0]  in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ID_W-1:0]   out_id
);
   out_st_t           st_q, st_d;
   logic [DATA_W-1:0] data_q, data_d;
   req_id_t           id_q, id_d;
   req_id_t           gnt;
   logic              any;
   logic              can_load;
   logic              xfer;
   logic [DATA_W-1:0] mux_y;

`ifdef MUX4_ARB_ROUND_ROBIN_EN
   localparam req_id_t PTR_RST = req_id_t'(RESET_PTR);
   req_id_t ptr_q, ptr_d;

   rr_pick4 u_pick (
      .in_valid (in_valid),
      .ptr      (ptr_q),
      .gnt      (gnt),
      .any      (any)
   );
`else
   logic unused_reset_ptr;
   assign unused_reset_ptr = ^RESET_PTR;

   rr_pick4 u_pick (
      .in_valid (in_valid),
      .gnt      (gnt),
      .any      (any)
   );
`endif

   mux_4_1 u_mux (
      .in0 (in_data0),
      .in1 (in_data1),
      .in2 (in_data2),
      .in3 (in_data3),
      .sel (gnt),
      .y   (mux_y)
   );

   always_comb begin
      // Gate with rst_n so no requester sees ready during reset.
      can_load = rst_n & ((st_q == ST_EMPTY) | out_ready);
      xfer     = can_load & any;
      in_ready = '0;
      if (xfer)
         in_ready[gnt] = 1'b1;
      st_d   = st_q;
      data_d = data_q;
      id_d   = id_q;
`ifdef MUX4_ARB_ROUND_ROBIN_EN
      ptr_d  = ptr_q;
`endif
      if (xfer) begin
         st_d   = ST_FULL;
         data_d = mux_y;
         id_d   = gnt;
`ifdef MUX4_ARB_ROUND_ROBIN_EN
         ptr_d  = gnt + req_id_t'(1);
`endif
      end else if (out_ready) begin
         st_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_EMPTY;
         data_q <= '0;
         id_q   <= '0;
`ifdef MUX4_ARB_ROUND_ROBIN_EN
         ptr_q  <= PTR_RST;
`endif
      end else begin
         st_q   <= st_d;
         data_q <= data_d;
         id_q   <= id_d;
`ifdef MUX4_ARB_ROUND_ROBIN_EN
         ptr_q  <= ptr_d;
`endif
      end
   end

   assign out_valid = (st_q == ST_FULL);
   assign out_data  = data_q;
   assign out_id    = id_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_mux4_rr_arbiter;
   import mux4_arb_pkg::*;

   localparam int RP = 0;
`ifdef MUX4_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] in_valid = 4'h0;
   logic [3:0] d [4];
   logic       out_ready = 1'b0;
   logic [3:0] in_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic [1:0] out_id;

   int tests = 0;
   int fails = 0;

   bit         m_full = 1'b0;
   logic [3:0] m_data = 4'h0;
   int         m_id = 0;
   int         m_ptr = RP;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.RESET_PTR(RP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (d[0]),
      .in_data1  (d[1]),
      .in_data2  (d[2]),
      .in_data3  (d[3]),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   function automatic int pick(logic [3:0] v, int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4] === 1'b1) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [31:0] exp_ready();
      int g;
      if (rst_n !== 1'b1) return 0;
      g = pick(in_valid, m_ptr);
      if (g >= 0 && (!m_full || out_ready)) return 32'd1 << g;
      return 0;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge rst_n) begin
      m_full = 1'b0;
      m_data = 4'h0;
      m_id   = 0;
      m_ptr  = RP;
   end

   always @(posedge clk) begin
      int g;
      if (rst_n === 1'b1) begin
         g = pick(in_valid, m_ptr);
         if (g >= 0 && (!m_full || out_ready)) begin
            m_full = 1'b1;
            m_data = d[g];
            m_id   = g;
            if (RR) m_ptr = (g + 1) % 4;
         end else if (out_ready) begin
            m_full = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, exp_ready());
      chk("out_valid", out_valid, m_full);
      chk("out_data", out_data, m_data);
      chk("out_id", out_id, m_id);
   end

   initial begin
      int e;
      for (int i = 0; i < 4; i++) d[i] = 4'hA + 4'(i);
      in_valid  = 4'hF;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      tick();
      tick();
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_id", out_id, 0);
      rst_n = 1'b1;

      for (int k = 0; k < 5; k++) begin
         tick();
         #1;
         e = RR ? (k % 4) : 0;
         chk("rr_id", out_id, e);
         chk("rr_data", out_data, 4'hA + e);
      end

      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         chk("bp_id", out_id, 0);
         chk("bp_data", out_data, 4'hA);
         chk("bp_ready", in_ready, 0);
         chk("bp_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      tick();
      #1;
      chk("bp_resume_id", out_id, RR ? 1 : 0);

      in_valid = 4'b0100;
      tick();
      #1;
      chk("sparse_pre_id", out_id, 2);
      in_valid = 4'b0010;
      #1;
      chk("sparse_ready", in_ready, 4'b0010);
      tick();
      #1;
      chk("sparse_id", out_id, 1);
      in_valid = 4'hF;
      #1;
      chk("ptr_after", in_ready, RR ? 4'b0100 : 4'b0001);

      tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_data", out_data, 0);
      rst_n = 1'b1;
      tick();
      #1;
      chk("post_rst_id", out_id, RP);
      chk("post_rst_data", out_data, 4'hA + RP);

      repeat (400) begin
         tick();
         in_valid = 4'($urandom);
         for (int i = 0; i < 4; i++) d[i] = 4'($urandom);
         out_ready = ($urandom % 4) != 0;
         rst_n = ($urandom % 50) != 0;
      end
      rst_n = 1'b1;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
